// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with a runtime-programmable pattern/length, overlap and
// Mealy/Moore selection, plus a saturating match counter.
module seq_detector_param #(
  parameter int unsigned        MAX_LEN     = 8,
  parameter int unsigned        CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(8'b0000_1010),
  parameter int unsigned        RST_LEN     = 4,
  localparam int unsigned       LW          = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               x,
  input  logic               in_valid,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  input  logic               cfg_moore,
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_count
);

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LW-1:0]      len_q, len_d;
  logic               ovl_q, ovl_d;
  logic               moore_q, moore_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LW-1:0]      fill_q, fill_d;
  logic               match_q, match_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               acc_c;
  logic               hit_c;
  logic [MAX_LEN-1:0] window_c;
  logic [MAX_LEN-1:0] mask_c;
  logic [LW-1:0]      len_m1_c;
  logic [LW-1:0]      len_ld_c;

  // Next-state: history/fill tracking, hit detection, config load and counter.
  always_comb begin
    pat_d    = pat_q;
    len_d    = len_q;
    ovl_d    = ovl_q;
    moore_d  = moore_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    match_d  = 1'b0;
    cnt_d    = cnt_q;
    mask_c   = '0;

    acc_c    = in_valid & ~cfg_we;
    window_c = {hist_q[MAX_LEN-2:0], x};
    len_m1_c = len_q - LW'(1);
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      mask_c[i] = (i < 32'(len_q));
    end
    // Only the low L bits of the window take part in the comparison.
    hit_c = acc_c && (fill_q >= len_m1_c) &&
            (((window_c ^ pat_q) & mask_c) == '0);

    if (cfg_len == '0) begin
      len_ld_c = LW'(1);
    end else if (cfg_len > LW'(MAX_LEN)) begin
      len_ld_c = LW'(MAX_LEN);
    end else begin
      len_ld_c = cfg_len;
    end

    if (cfg_we) begin
      pat_d   = cfg_pattern;
      len_d   = len_ld_c;
      ovl_d   = cfg_overlap;
      moore_d = cfg_moore;
      hist_d  = '0;
      fill_d  = '0;
    end else if (acc_c) begin
      hist_d = window_c;
      if (hit_c && !ovl_q) begin
        fill_d = '0;
      end else if (fill_q < len_q) begin
        fill_d = fill_q + LW'(1);
      end
    end

    match_d = hit_c;

    if (cnt_clr) begin
      cnt_d = '0;
    end else if (hit_c && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q   <= RST_PATTERN;
      len_q   <= LW'(RST_LEN);
      ovl_q   <= 1'b1;
      moore_q <= 1'b0;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      moore_q <= moore_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
    end
  end

  // Mealy output is the live hit; Moore output is the hit delayed one cycle.
  assign match       = moore_q ? match_q : hit_c;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_seq_detector_param;
  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned LW      = $clog2(MAX_LEN + 1);
  localparam int          CMAX    = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               x = 1'b0;
  logic               in_valid = 1'b0;
  logic               cfg_we = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LW-1:0]      cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               cfg_moore = 1'b0;
  logic               cnt_clr = 1'b0;
  logic               match;
  logic [CNT_W-1:0]   match_count;

  int total = 0;
  int bad   = 0;

  seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_moore(cfg_moore), .cnt_clr(cnt_clr), .match(match), .match_count(match_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of fresh accepted bits, newest at the back.
  bit   model_on = 0;
  bit   q[$];
  bit   tmp[$];
  logic [MAX_LEN-1:0] m_pat;
  int   m_len;
  bit   m_ovl, m_moore, m_mq;
  int   m_cnt;

  function automatic int clamp_len(input int l);
    if (l == 0) return 1;
    if (l > MAX_LEN) return MAX_LEN;
    return l;
  endfunction

  always @(negedge clk) begin
    bit acc, h, exp_m;
    if (rst) begin
      model_on = 1;
      q.delete();
      m_pat = MAX_LEN'(8'b0000_1010);
      m_len = 4; m_ovl = 1; m_moore = 0; m_mq = 0; m_cnt = 0;
    end else if (model_on) begin
      acc = in_valid && !cfg_we;
      h = 0;
      tmp = q;
      if (acc) begin
        tmp.push_back(x);
        if (tmp.size() >= m_len) begin
          h = 1;
          for (int i = 0; i < m_len; i++)
            if (tmp[tmp.size() - 1 - i] != m_pat[i]) h = 0;
        end
      end
      exp_m = m_moore ? m_mq : h;
      chk("match", int'(match), int'(exp_m));
      chk("match_count", int'(match_count), m_cnt);
      if (cfg_we) begin
        m_pat = cfg_pattern; m_len = clamp_len(int'(cfg_len));
        m_ovl = cfg_overlap; m_moore = cfg_moore; m_mq = 0;
        q.delete();
      end else begin
        m_mq = h;
        if (acc) begin
          q = tmp;
          if (q.size() > MAX_LEN) void'(q.pop_front());
          if (h && !m_ovl) q.delete();
        end
      end
      if (cnt_clr) m_cnt = 0;
      else if (h && m_cnt < CMAX) m_cnt++;
    end
  end

  logic last_match;

  // Apply inputs for one cycle, sample match mid-cycle, release strobes.
  task automatic step(input logic xi, input logic vi);
    x = xi; in_valid = vi;
    #3 last_match = match;
    @(posedge clk); #1;
    cfg_we = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic cfg(input logic [MAX_LEN-1:0] p, input int l, input bit o,
                     input bit mo, input bit clr);
    cfg_pattern = p; cfg_len = LW'(l); cfg_overlap = o; cfg_moore = mo;
    cfg_we = 1'b1; cnt_clr = clr;
    step(1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] m;
    logic [7:0] pat8;
    int pulses;
    bit on_last;

    rst = 1'b1;
    step(0, 0); step(0, 0);
    rst = 1'b0;
    step(0, 0);
    chk("reset_match", int'(last_match), 0);
    chk("reset_count", int'(match_count), 0);

    // Default 1010, overlap, Mealy
    m = '0;
    for (int i = 0; i < 6; i++) begin
      step(1'(i % 2 == 0), 1);
      m = {m[6:0], last_match};
    end
    chk("mealy_overlap_pulses", int'(m[5:0]), 'b000101);
    chk("mealy_overlap_count", int'(match_count), 2);

    // Non-overlap, Moore
    cfg(8'b0000_1010, 4, 0, 1, 1);
    m = '0;
    for (int i = 0; i < 6; i++) begin
      step(1'(i % 2 == 0), 1);
      m = {m[6:0], last_match};
    end
    step(0, 0);
    m = {m[6:0], last_match};
    chk("moore_nonovl_pulses", int'(m[6:0]), 'b0000100);
    chk("moore_nonovl_count", int'(match_count), 1);
    pulses = 0;
    step(0, 1); pulses += int'(last_match);
    step(1, 1); pulses += int'(last_match);
    step(0, 1); pulses += int'(last_match);
    step(0, 0); pulses += int'(last_match);
    chk("moore_nonovl_tail", pulses, 0);

    // 8-bit pattern with gaps
    pat8 = 8'b1100_1101;
    cfg(pat8, 8, 1, 0, 1);
    pulses = 0; on_last = 0;
    for (int i = 7; i >= 0; i--) begin
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        step(1'($urandom_range(0, 1)), 0); pulses += int'(last_match);
      end
      step(pat8[i], 1); pulses += int'(last_match);
      if (i == 0) on_last = last_match;
    end
    step(0, 0);
    chk("len8_pulses", pulses, 1);
    chk("len8_on_last", int'(on_last), 1);
    chk("len8_count", int'(match_count), 1);

    // cfg_len 12 clamps to 8
    cfg(pat8, 12, 1, 0, 0);
    for (int i = 7; i >= 0; i--) step(pat8[i], 1);
    chk("len12_clamp_hit", int'(last_match), 1);
    step(0, 0);
    chk("len12_clamp_count", int'(match_count), 2);

    // cfg_len 0 -> L=1, every valid 1 matches
    cfg(8'b0000_0001, 0, 1, 0, 0);
    step(1, 1); step(0, 1); step(1, 1); step(1, 1); step(1, 0);
    chk("len0_gap_nomatch", int'(last_match), 0);
    chk("len0_count", int'(match_count), 5);

    // Saturation at 15, then clear beats hit
    cfg(8'b0000_0001, 1, 1, 0, 1);
    for (int i = 0; i < 20; i++) step(1, 1);
    chk("sat_count", int'(match_count), CMAX);
    cnt_clr = 1'b1;
    step(1, 1);
    chk("clr_vs_hit", int'(match_count), 0);

    // cfg_we on completing bit
    cfg(8'b0000_1010, 4, 1, 0, 1);
    step(1, 1); step(0, 1); step(1, 1);
    cfg_pattern = 8'b0000_1010; cfg_len = LW'(4); cfg_overlap = 1; cfg_moore = 0;
    cfg_we = 1'b1;
    step(0, 1);
    chk("cfgwe_mealy_forced0", int'(last_match), 0);
    pulses = 0;
    step(0, 1); pulses += int'(last_match);
    step(1, 1); pulses += int'(last_match);
    step(0, 1); pulses += int'(last_match);
    step(0, 0);
    chk("cfgwe_hist_cleared", pulses, 0);
    chk("cfgwe_count", int'(match_count), 0);

    // Reset mid-pattern
    cfg(8'b0000_0110, 3, 1, 1, 0);
    step(1, 1); step(0, 1); step(1, 1);
    rst = 1'b1;
    step(0, 0);
    rst = 1'b0;
    step(0, 0);
    chk("rst_mid_match", int'(last_match), 0);
    chk("rst_mid_count", int'(match_count), 0);
    m = '0;
    step(0, 1); m = {m[6:0], last_match};
    step(1, 1); m = {m[6:0], last_match};
    step(0, 1); m = {m[6:0], last_match};
    step(1, 1); m = {m[6:0], last_match};
    step(0, 1); m = {m[6:0], last_match};
    chk("rst_then_pulses", int'(m[4:0]), 'b00001);

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) begin
        cfg_we = 1'b1;
        cfg_pattern = MAX_LEN'($urandom);
        cfg_len = ($urandom_range(0, 3) == 0) ? LW'($urandom_range(0, 15))
                                              : LW'($urandom_range(0, 4));
        cfg_overlap = 1'($urandom_range(0, 1));
        cfg_moore = 1'($urandom_range(0, 1));
      end
      cnt_clr = ($urandom_range(0, 29) == 0);
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7));
    end
    rst = 1'b0;
    step(0, 0); step(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial bit-pattern detector with a runtime-programmable pattern (1..MAX_LEN bits), overlapping or non-overlapping detection, Mealy or Moore output timing, and a saturating match counter. It replaces the fixed-pattern single-sequence detector FSMs in the sequence-detector library. It sits directly on a 1-bit serial stream qualified by `in_valid`, and is configured through a simple write strobe.

## Interface
- `MAX_LEN`, 8: maximum pattern length in bits (≥2).
- `CNT_W`, 8: width of the match counter.
- `RST_PATTERN`, 8'b0000_1010: pattern loaded at reset (low MAX_LEN bits used).
- `RST_LEN`, 4: pattern length loaded at reset.
- `LW`, $clog2(MAX_LEN+1): width of the length field (derived, not overridden).

Ports:
- `clk`, in, 1: clock; all state updates on posedge.
- `rst`, in, 1: reset, synchronous, active-high.
- `x`, in, 1: serial data bit.
- `in_valid`, in, 1: `x` is sampled only when high; otherwise the cycle is ignored.
- `cfg_we`, in, 1: load `cfg_*` fields into configuration registers.
- `cfg_pattern`, in, MAX_LEN: pattern; first-received bit = bit [len-1], last = bit [0].
- `cfg_len`, in, LW: pattern length.
- `cfg_overlap`, in, 1: 1 = overlapping detection, 0 = non-overlapping.
- `cfg_moore`, in, 1: 0 = Mealy output, 1 = Moore (registered) output.
- `cnt_clr`, in, 1: synchronous clear of `match_count`.
- `match`, out, 1: detection pulse.
- `match_count`, out, CNT_W: number of detections, saturating.

## Operation
- Config registers: pattern, len, overlap, moore. Reset loads RST_PATTERN, RST_LEN, overlap=1, moore=0.
- Effective length `L`:
  - cfg_len=0 → 1.
  - cfg_len>MAX_LEN → MAX_LEN.
  - Clamping is applied at load.
- History: MAX_LEN-bit shift register `hist` plus fill counter `fill` (0..L, saturating). On each accepted bit (`in_valid`=1, `cfg_we`=0): `hist` <= {hist, x}, `fill` <= min(fill+1, L).
- Hit condition, evaluated on an accepted bit: `fill` ≥ L-1 and {hist[L-2:0], x} == pattern[L-1:0]. For L=1: x == pattern[0].
- Overlap=1: history is kept after a hit, so suffixes can start the next match. Example: 1010 on 1010101 gives 2 hits.
- Overlap=0: on a hit, `fill` <= 0. The next match needs L fresh bits. Example: 1010 on 1010101 gives 1 hit.
- Mealy: `match` = combinational hit, in the same cycle as the completing bit. It depends on the current `x` and `in_valid`.
- Moore: `match` is a register set to hit, high for exactly the cycle after the completing bit. The register clears on any cycle without a hit, including `in_valid`=0 cycles.
- Counter:
  - Increments by 1 on each hit, in both modes.
  - Holds at 2^CNT_W-1.
  - `cnt_clr` has priority over increment; a hit in the clear cycle is lost.
- `cfg_we`:
  - Loads config, clears `hist`, `fill`, and the Moore `match` register.
  - Does not clear `match_count`.
  - An accepted bit in the same cycle is discarded, with no hit and no count.
  - In Mealy mode, `match` is forced 0 in that cycle.

## Timing
- Reset values: match=0, match_count=0, hist=0, fill=0, config = reset values.
- `rst` overrides `cfg_we`, `cnt_clr`, and data in the same cycle. Reset mid-pattern discards partial history; a pattern straddling reset is never detected.
- Mealy latency: 0 cycles (same-cycle). Moore latency: 1 cycle.
- `match_count` reflects a hit on the clock edge after the completing bit, in both modes.
- `in_valid`=0 gaps of any length do not break a partial match.
- Mode or pattern change takes effect on bits accepted after the `cfg_we` cycle.

## Test plan
- Reset defaults (1010, overlap, Mealy), stream 1,0,1,0,1,0 all valid → match high with bits 4 and 6, same cycle; match_count=2.
- Same stream after `cfg_we` with overlap=0, moore=1 → single match pulse the cycle after bit 4; match_count=1. Then 0,1,0 → no further match until a fresh 1010.
- Program pattern=8'b1100_1101, L=8; send it with `in_valid` gaps of 0–3 cycles between bits → exactly one match on the 8th accepted bit. Send `cfg_len`=12 → clamps to 8; `cfg_len`=0 with pattern bit0=1 → every valid 1 matches.
- CNT_W=4: force 20 hits → match_count saturates at 15. `cnt_clr` asserted in the same cycle as a hit → count 0.
- `cfg_we` in the same cycle as the completing bit → no match, no count; history cleared, so next 3 bits 0,1,0 do not match.
- `rst` asserted after 1,0,1 → outputs 0; then 0 → no match; then 1,0,1,0 → match.
